// File: rtl/turf_cout_pkg.sv
// Shared constants and frame-kind encoding for the COUTTIO transmit framer.
package turf_cout_pkg;

  localparam int          NIBBLES_PER_WORD   = 8;
  localparam logic [31:0] TRAIN_DEFAULT_WORD = 32'h6996A55A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TRAIN = 2'd2
  } cout_mode_t;

endpackage

// File: rtl/turf_cout_tx.sv
// COUTTIO transmit framer: 32-bit words sent LSB nibble first in fixed 8-cycle
// frames, with a one-word holding buffer and a repeating training pattern.
module turf_cout_tx
  import turf_cout_pkg::*;
#(
  parameter logic [31:0] TRAIN_DEFAULT = TRAIN_DEFAULT_WORD,
  parameter int          COUNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   train_en_i,
  input  logic [31:0]            train_value_i,
  input  logic [31:0]            s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  output logic [3:0]             cout_o,
  output logic                   word_start_o,
  output logic [1:0]             tx_mode_o,
  output logic [COUNT_WIDTH-1:0] tx_count_o
);

  localparam int             PH_W       = $clog2(NIBBLES_PER_WORD);
  localparam logic [PH_W-1:0] LAST_PHASE = PH_W'(NIBBLES_PER_WORD - 1);

  logic [PH_W-1:0]        phase_q, phase_d;
  logic [31:0]            shreg_q, shreg_d;
  logic [31:0]            buf_q, buf_d;
  logic                   full_q, full_d;
  logic                   s_tready_q, s_tready_d;
  cout_mode_t             mode_q, mode_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   hs;
  logic                   bypass;

  assign hs = s_tvalid && s_tready_q;

  always_comb begin
    phase_d = phase_q + 1'b1;
    shreg_d = {4'h0, shreg_q[31:4]};
    buf_d   = buf_q;
    full_d  = full_q;
    mode_d  = mode_q;
    count_d = count_q;
    bypass  = 1'b0;

    // Frame boundary: training pre-empts data, buffered data pre-empts bypass
    if (phase_q == LAST_PHASE) begin
      if (train_en_i) begin
        shreg_d = (train_value_i == '0) ? TRAIN_DEFAULT : train_value_i;
        mode_d  = TRAIN;
      end else if (full_q) begin
        shreg_d = buf_q;
        full_d  = 1'b0;
        mode_d  = DATA;
        count_d = count_q + 1'b1;
      end else if (hs) begin
        shreg_d = s_tdata;
        bypass  = 1'b1;
        mode_d  = DATA;
        count_d = count_q + 1'b1;
      end else begin
        shreg_d = '0;
        mode_d  = IDLE;
      end
    end

    if (hs && !bypass) begin
      buf_d  = s_tdata;
      full_d = 1'b1;
    end

    s_tready_d = !full_d;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      phase_q    <= '0;
      shreg_q    <= '0;
      full_q     <= 1'b0;
      s_tready_q <= 1'b0;
      mode_q     <= IDLE;
      count_q    <= '0;
    end else begin
      phase_q    <= phase_d;
      shreg_q    <= shreg_d;
      full_q     <= full_d;
      s_tready_q <= s_tready_d;
      mode_q     <= mode_d;
      count_q    <= count_d;
    end
  end

  // Buffer contents are qualified by full_q, so they need no reset
  always_ff @(posedge clk_i) begin
    buf_q <= buf_d;
  end

  assign s_tready     = s_tready_q;
  assign cout_o       = shreg_q[3:0];
  assign word_start_o = (phase_q == '0);
  assign tx_mode_o    = mode_q;
  assign tx_count_o   = count_q;

endmodule

// File: tb/tb_turf_cout_tx.sv
// Bench for turf_cout_tx: directed vector table, directed multi-cycle sequences
// and randomized traffic against a frame-level reference model.
module tb_turf_cout_tx;
  import turf_cout_pkg::*;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          train_en = 1'b0;
  logic [31:0]   train_val = '0;
  logic [31:0]   tdata = '0;
  logic          tvalid = 1'b0;
  logic          tready;
  logic [3:0]    cout;
  logic          wstart;
  logic [1:0]    tmode;
  logic [CW-1:0] tcount;

  always #5 clk = ~clk;

  turf_cout_tx #(.COUNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .train_en_i(train_en), .train_value_i(train_val),
    .s_tdata(tdata), .s_tvalid(tvalid), .s_tready(tready), .cout_o(cout),
    .word_start_o(wstart), .tx_mode_o(tmode), .tx_count_o(tcount)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame being sent is a whole word, nibble picked by phase;
  // pending words sit in a queue that the ready rule keeps at depth <= 1.
  int          m_phase;
  logic [31:0] m_frame;
  logic [1:0]  m_mode;
  int          m_count;
  logic [31:0] m_q[$];
  bit          m_ready;

  task automatic model_reset();
    m_phase = 0; m_frame = '0; m_mode = 2'd0; m_count = 0; m_q.delete(); m_ready = 0;
  endtask

  task automatic model_edge(input bit tv, input logic [31:0] td, input bit ten,
                            input logic [31:0] tval);
    bit hs;
    bit taken;
    hs = tv && m_ready;
    taken = 0;
    if (m_phase == 7) begin
      if (ten) begin
        m_frame = (tval == 0) ? 32'h6996A55A : tval;
        m_mode  = 2'd2;
      end else if (m_q.size() > 0) begin
        m_frame = m_q.pop_front();
        m_mode  = 2'd1;
        m_count = (m_count + 1) % (1 << CW);
      end else if (hs) begin
        m_frame = td;
        m_mode  = 2'd1;
        m_count = (m_count + 1) % (1 << CW);
        taken   = 1;
      end else begin
        m_frame = '0;
        m_mode  = 2'd0;
      end
    end
    if (hs && !taken) m_q.push_back(td);
    m_ready = (m_q.size() == 0);
    m_phase = (m_phase + 1) % 8;
  endtask

  task automatic compare_model(input string name);
    logic [11:0] exp, act;
    logic [3:0]  nib;
    logic [CW-1:0] c;
    nib = m_frame[4*m_phase +: 4];
    c   = CW'(m_count);
    exp = {nib, (m_phase == 0), m_mode, c, m_ready};
    act = {cout, wstart, tmode, tcount, tready};
    check(name, act, exp);
  endtask

  // Called at a falling edge: compare, drive inputs, advance model and one clock
  task automatic step(input bit tv, input logic [31:0] td, input bit ten,
                      input logic [31:0] tval);
    compare_model("cyc");
    tvalid = tv; tdata = td; train_en = ten; train_val = tval;
    model_edge(tv, td, ten, tval);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic advance_to(input int ph, input bit ten, input logic [31:0] tval);
    for (int i = 0; i < 16 && m_phase != ph; i++) step(0, '0, ten, tval);
    check("advance_phase", 64'(m_phase), 64'(ph));
  endtask

  task automatic collect(input bit ten, input logic [31:0] tval,
                         output logic [31:0] w, output logic [1:0] md);
    check("collect_ws", 64'(wstart), 64'd1);
    md = tmode;
    for (int i = 0; i < 8; i++) begin
      w[4*i +: 4] = cout;
      step(0, '0, ten, tval);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tvalid = 0; tdata = '0; train_en = 0; train_val = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          tv;
    logic [31:0] td;
    logic [3:0]  cout;
    bit          ws;
    logic [1:0]  mode;
    logic [CW-1:0] cnt;
    bit          rdy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit tv, input logic [31:0] td, input logic [3:0] c,
                              input bit ws, input logic [1:0] md, input int cnt, input bit rdy);
    vec_t v;
    v.tv = tv; v.td = td; v.cout = c; v.ws = ws; v.mode = md; v.cnt = CW'(cnt); v.rdy = rdy;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] w;
    logic [1:0]  md;
    bit          ten;
    logic [31:0] tval;
    int          k;
    logic [31:0] words[4];

    #100000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    logic [1:0]  md;
    bit          ten;
    logic [31:0] tval;
    int          k;
    logic [31:0] words[4];

    // Single word offered at phase 2 right after reset, cycle by cycle
    add(0, '0, 4'h0, 1, 2'd0, 0, 0);
    add(0, '0, 4'h0, 0, 2'd0, 0, 1);
    add(1, 32'h87654321, 4'h0, 0, 2'd0, 0, 1);
    for (int i = 3; i < 8; i++) add(0, '0, 4'h0, 0, 2'd0, 0, 0);
    add(0, '0, 4'h1, 1, 2'd1, 1, 1);
    for (int i = 2; i <= 8; i++) add(0, '0, 4'(i), 0, 2'd1, 1, 1);
    add(0, '0, 4'h0, 1, 2'd0, 1, 1);

    @(negedge clk);
    check("rst_state", {cout, wstart, tmode, tcount, tready}, {4'h0, 1'b1, 2'd0, 4'h0, 1'b0});
    do_reset();
    foreach (vecs[i]) begin
      check("vec", {cout, wstart, tmode, tcount, tready},
            {vecs[i].cout, vecs[i].ws, vecs[i].mode, vecs[i].cnt, vecs[i].rdy});
      tvalid = vecs[i].tv; tdata = vecs[i].td;
      @(posedge clk);
      @(negedge clk);
    end

    // Idle after reset
    do_reset();
    for (int i = 0; i < 24; i++) step(0, '0, 0, '0);

    // Back-to-back stream of four words
    words = '{32'h11112222, 32'hDEADBEEF, 32'h0F0F0F0F, 32'hCAFEF00D};
    k = 0;
    for (int i = 0; i < 60 && k < 4; i++) begin
      bit r;
      r = m_ready;
      step(1, words[k], 0, '0);
      if (r) k++;
    end
    check("b2b_accepted", 64'(k), 64'd4);
    for (int i = 0; i < 24; i++) step(0, '0, 0, '0);
    check("b2b_count", 64'(tcount), 64'd4);

    // Training raised mid-frame, default then programmed pattern
    do_reset();
    advance_to(3, 0, '0);
    advance_to(0, 1, '0);
    collect(1, '0, w, md);
    check("train_def_word", w, 32'h6996A55A);
    check("train_def_mode", 64'(md), 64'd2);
    collect(1, 32'hA5A5A5A5, w, md);
    collect(1, 32'hA5A5A5A5, w, md);
    check("train_val_word", w, 32'hA5A5A5A5);
    check("train_val_mode", 64'(md), 64'd2);

    // Word buffered, then training: word held until training ends
    do_reset();
    advance_to(2, 0, '0);
    step(1, 32'h13579BDF, 0, '0);
    advance_to(4, 0, '0);
    for (int i = 0; i < 20; i++) step(i[0], 32'hBADBAD00, 1, '0);
    check("train_hold_rdy", 64'(tready), 64'd0);
    advance_to(3, 1, '0);
    advance_to(0, 0, '0);
    collect(0, '0, w, md);
    check("held_word", w, 32'h13579BDF);
    check("held_mode", 64'(md), 64'd1);

    // Reset at phase 4 of a data frame with the buffer full
    do_reset();
    advance_to(1, 0, '0);
    step(1, 32'hAAAA5555, 0, '0);
    advance_to(0, 0, '0);
    step(1, 32'h77778888, 0, '0);
    advance_to(4, 0, '0);
    check("pre_rst_mode", 64'(tmode), 64'd1);
    tvalid = 0;
    #2 rst_n = 1'b0;
    #1 check("async_rst", {cout, wstart, tmode, tcount, tready}, {4'h0, 1'b1, 2'd0, 4'h0, 1'b0});
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) step(0, '0, 0, '0);
    check("post_rst_count", 64'(tcount), 64'd0);

    // Randomized traffic, long enough to wrap the counter
    do_reset();
    ten = 0; tval = '0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) ten = !ten;
      if ($urandom_range(0, 99) == 0) tval = $urandom_range(0, 1) ? '0 : $urandom;
      step($urandom_range(0, 1), $urandom, ten, tval);
    end
    compare_model("rand_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/turf_cout_tx.md
# turf_cout_tx

Transmit-side framer for the TURFIO→TURF COUTTIO serial control link, the reverse direction of the CIN receive path. It accepts 32-bit command words over a valid/ready stream and emits one 4-bit nibble per clock, LSB nibble first, to the 4:1 DDR OSERDES driving COUTTIO. Words occupy fixed 8-cycle frames. A training mode repeats a programmable pattern so the TURF-side receiver can center its IDELAY and bitslip to word alignment.

## Interface
Parameters:
- TRAIN_DEFAULT, 32'h6996A55A, training word used when `train_value_i` is all zero.
- COUNT_WIDTH, 16, width of the transmitted-word counter.

Ports:
- clk_i  in  1  parallel (CLKDIV-rate) clock; the same clock drives the OSERDES CLKDIV.
- rst_n_i  in  1  asynchronous, active-low reset.
- train_en_i  in  1  training request, level; sampled only at frame boundaries.
- train_value_i  in  32  training word, sampled only at frame boundaries.
- s_tdata  in  32  command word.
- s_tvalid  in  1  command word valid.
- s_tready  out  1  registered; high when the holding buffer is empty.
- cout_o  out  4  nibble to OSERDES; bit 0 is first on the wire.
- word_start_o  out  1  high on the cycle `cout_o` carries nibble 0 of a frame.
- tx_mode_o  out  2  kind of frame on `cout_o`: 0 idle, 1 data, 2 train.
- tx_count_o  out  COUNT_WIDTH  count of data frames sent, wraps.

## Operation
- A free-running 3-bit `phase` counter runs from 0 to 7 and wraps. It resets to 0.
- The shift register `shreg[31:0]` drives `cout_o = shreg[3:0]`.
- At each edge with `phase != 7`, `shreg >>= 4`.
- The edge at `phase == 7` is the frame boundary. It loads the next frame in this priority order:
  1. train (`train_en_i == 1`): load `train_value_i`, or `TRAIN_DEFAULT` if `train_value_i` is zero. The buffer is left untouched.
  2. buffer full: load the buffer, clear it, increment `tx_count_o`.
  3. bypass: buffer empty, `s_tvalid && s_tready` on this cycle, and not training. Load `s_tdata` directly and increment `tx_count_o`.
  4. otherwise: load 32'h0 (idle).
- Any `s_tvalid && s_tready` handshake not consumed by bypass writes the buffer and sets full.
- `tx_mode_o` is registered at the boundary to match the loaded frame.
- `s_tready` next-state is `!full_next`.
  - Consequence: after a bypass at phase 7, `s_tready` stays 1.
  - During training the buffer holds at most one word and `s_tready` stays low until training ends.
- `train_en_i` changes mid-frame never truncate a frame. They take effect at the next boundary.

## Timing
- Reset values while `rst_n_i` is low: `phase` 0, `shreg` 0, `cout_o` 0, `word_start_o` 1, `tx_mode_o` 0, `tx_count_o` 0, buffer empty, `s_tready` 0.
- The first clock after deassertion sets `s_tready` to 1.
- The first frame after reset is idle, covering phases 0–7.
- Latency, bypass: handshake on a phase-7 cycle puts nibble 0 on `cout_o` in the next cycle, with `word_start_o` = 1.
- Latency, buffered: a handshake with phase p < 7 puts nibble 0 on `cout_o` 7−p+1 cycles later.
- `word_start_o` is high exactly when `phase == 0`, on the same cycle as nibble 0.
- Throughput: at most one data word per 8 cycles. The buffer plus the shift register hold two words in flight.
- `tx_count_o` updates on the boundary edge, so it is visible during nibble 0 of the counted frame. It wraps from 2^COUNT_WIDTH−1 to 0.
- Asynchronous reset mid-frame or mid-training drops the in-flight word and any buffered word. No partial frame resumes.

## Structure
- Package `turf_cout_pkg` holds:
  - `NIBBLES_PER_WORD` = 8
  - `TRAIN_DEFAULT_WORD` = 32'h6996A55A
  - enum `cout_mode_t` {IDLE=0, DATA=1, TRAIN=2}
- Single flat module, no sub-modules. OSERDESE2 and OBUFDS instantiation stays in the parent TURF interface.

## Test plan
- Reset then idle, `s_tvalid` = 0: `cout_o` = 0 throughout, `word_start_o` high every 8th cycle, `tx_mode_o` = 0, `tx_count_o` = 0.
- Single word 32'h87654321 offered at phase 2: `s_tready` drops the next cycle. At the next boundary the nibbles are 1,2,3,4,5,6,7,8, `tx_mode_o` = 1, `tx_count_o` = 1, then `s_tready` returns high.
- Back-to-back stream with `s_tvalid` held high for 4 words: gapless data frames, one word per 8 cycles, `tx_count_o` = 4, and no word dropped or duplicated.
- `train_en_i` = 1 with `train_value_i` = 0, raised mid-frame: the current frame completes, then 32'h6996A55A repeats with `tx_mode_o` = 2. With `train_value_i` = 32'hA5A5A5A5, the frames carry that value.
- Word buffered, then training raised: the word is held and `s_tready` stays low. When training drops, the word is the first frame after training.
- Assert `rst_n_i` at phase 4 of a data frame with the buffer full: outputs immediately go to their reset values. After release, idle frames follow, and the old word is never emitted.
